// File: rtl/botao_pkg.sv
// Shared constants and types for the botao_ctrl push-button controller.
package botao_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_t;

endpackage

// File: rtl/botao_ctrl_if.sv
// Avalon-MM slave bus bundle for botao_ctrl; master side drives, slave side answers.
interface botao_ctrl_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/botao_debounce.sv
// Two-flop synchronizer plus counter-based debounce FSM for one button pin.
// Define BOTAO_DEBOUNCE_EN to build the FSM; otherwise level is the synchronized pin.
module botao_debounce
  import botao_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic PRESS_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_port,
  output logic level
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= ~PRESS_LEVEL;
      sync2 <= ~PRESS_LEVEL;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef BOTAO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  deb_state_t    state;
  deb_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          level_q;
  logic          level_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= STABLE;
      cnt     <= '0;
      level_q <= ~PRESS_LEVEL;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      level_q <= level_nxt;
    end
  end

  // Any sample that disagrees with the running count restarts from STABLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = level_q;
    case (state)
      STABLE: begin
        if (sync2 != level_q) begin
          state_nxt = PENDING;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt = '0;
        end
      end
      PENDING: begin
        if (sync2 == level_q) begin
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          level_nxt = sync2;
          state_nxt = STABLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level = level_q;
`else
  // Count length only matters when the FSM is built in.
  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES > 0);

  assign level = sync2;
`endif

endmodule

// File: rtl/botao_ctrl.sv
// Avalon-MM push-button controller: debounced level, press edge-capture and maskable irq.
// Debouncing is enabled by defining BOTAO_DEBOUNCE_EN (see botao_debounce).
module botao_ctrl
  import botao_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 500000,
  parameter logic PRESS_LEVEL     = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_port,
  botao_ctrl_if.slave  bus,
  output logic         irq
);

  logic        level;
  logic        pressed;
  logic        pressed_q;
  logic        press_evt;
  logic        wr_en;
  logic        irq_mask;
  logic        edgecap;
  logic [31:0] rd_nxt;
  logic        unused_wdata;

  botao_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .PRESS_LEVEL     (PRESS_LEVEL)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .level   (level)
  );

  assign pressed      = (level == PRESS_LEVEL);
  assign press_evt    = pressed & ~pressed_q;
  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata[31:1];

  // A press landing on the same edge as a clear must not be lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pressed_q <= 1'b0;
      irq_mask  <= 1'b0;
      edgecap   <= 1'b0;
    end else begin
      pressed_q <= pressed;
      if (wr_en && bus.address == ADDR_IRQMASK) begin
        irq_mask <= bus.writedata[0];
      end
      if (press_evt) begin
        edgecap <= 1'b1;
      end else if (wr_en && bus.address == ADDR_EDGECAP) begin
        edgecap <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_nxt = '0;
    case (bus.address)
      ADDR_DATA:    rd_nxt = {31'd0, pressed};
      ADDR_IRQMASK: rd_nxt = {31'd0, irq_mask};
      ADDR_EDGECAP: rd_nxt = {31'd0, edgecap};
      default:      rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_nxt;
    end
  end

  assign irq = edgecap & irq_mask;

endmodule

// File: doc/botao_ctrl.md
# botao_ctrl

Avalon-MM slave controller for a single push-button input: synchronizes the raw pin, debounces it with a counter-based state machine, latches press events in an edge-capture register and raises a maskable interrupt. Sits between the board button pin and the system interconnect, and replaces the plain one-bit input PIO for any button that software must poll or take interrupts from.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range ≥ 2.
- PRESS_LEVEL, 1'b0, pin level meaning "pressed" (board buttons are active-low).
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_port  input  1  raw, asynchronous button pin.
- address  input  2  word address of the register.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe, qualified by chipselect.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt, active-high.

## Operation
- Register map (word address):
  - 0 DATA: read-only; bit0 = debounced level, 1 = pressed (already polarity-corrected). Writes ignored.
  - 1 IRQMASK: read/write; bit0 enables irq. Upper bits read 0.
  - 2: reserved, reads 0, writes ignored.
  - 3 EDGECAP: bit0 set on every debounced press; any write (data ignored) clears it.
- Synchronizer: two flops on in_port, reset to the released level (!PRESS_LEVEL).
- Debounce FSM, states STABLE and PENDING, counter cnt of width $clog2(DEBOUNCE_CYCLES):
  - STABLE: sync == level → stay, cnt = 0. sync != level → PENDING, cnt = 1.
  - PENDING: sync == level → STABLE, cnt = 0 (bounce rejected). sync != level and cnt == DEBOUNCE_CYCLES-1 → level <= sync, STABLE, cnt = 0. Otherwise cnt++.
- Press event: level transitions released → pressed. Release transitions generate no event.
- EDGECAP set and write-clear in the same cycle: set wins.
- irq = EDGECAP[0] & IRQMASK[0], combinational from registers; no other path to irq.
- Reset values: readdata 0, irq 0, IRQMASK 0, EDGECAP 0, level released, FSM STABLE, cnt 0.

## Timing
- Read latency 1: readdata reflects the address presented in the previous cycle; readdata updates every cycle irrespective of chipselect.
- Writes take effect at the clock edge where chipselect=1 and write_n=0.
- in_port change to level change: 2 (sync) + DEBOUNCE_CYCLES cycles, given the pin is stable throughout.
- Level becomes pressed at edge N → EDGECAP[0] = 1 and irq (if masked in) from edge N+1.
- Reset asserted mid-count: FSM returns to STABLE at released level; no event produced on reset release even if the button is held — the press is reported DEBOUNCE_CYCLES+2 cycles later through the normal path.

## Configuration
- BOTAO_DEBOUNCE_EN defined: FSM and counter as above.
- Not defined: level = second synchronizer flop directly; FSM and counter not instantiated; latency in_port→level = 2 cycles; DEBOUNCE_CYCLES unused. Register map and edge/irq behaviour unchanged.

## Structure
- Package botao_pkg: register address constants (ADDR_DATA=0, ADDR_IRQMASK=1, ADDR_EDGECAP=3) and the debounce state enum {STABLE, PENDING}.
- One sub-module, botao_debounce: synchronizer + FSM + counter, output level; the macro lives inside it. Register file, edge detect and irq in botao_ctrl.

## Test plan
- DEBOUNCE_CYCLES=4, reset, in_port held 1 → DATA reads 0, EDGECAP 0, irq 0, no event after reset release.
- Drive in_port 0 steady → DATA bit0 = 1 exactly 6 cycles after the change, EDGECAP[0]=1 one cycle later; irq stays 0 with IRQMASK=0.
- Write IRQMASK=1, then pulse in_port 0 for 3 cycles among 1s (bounce) → level never changes, EDGECAP unchanged, irq 0; then hold 0 → irq 1.
- With irq high, write EDGECAP (0xFFFFFFFF) → EDGECAP 0, irq 0 next cycle; release button → no new event.
- Press event coincident with EDGECAP write → EDGECAP[0] remains 1.
- Assert reset_n low while PENDING (cnt=2) → all outputs 0, counter cleared; build without BOTAO_DEBOUNCE_EN → level follows in_port after 2 cycles, one-cycle glitch produces an event.
